// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Multi-cycle RISC-V control sequencer. It steps through fetch, decode, execute,
//   memory and write-back, and drives the PC, memory and register-file strobes for
//   each opcode class. It stalls while memory is busy and halts on ECALL or when a
//   memory access times out.
//
// Parameters
//   MEM_TIMEOUT  maximum number of consecutive IF/MEM cycles spent waiting on
//                mem_ready before the controller halts with an error (>= 1)
//
// Ports
//   clk        in   clock; all state updates happen on the rising edge
//   reset      in   asynchronous, active-high; returns the FSM to IF and clears
//                   the counters and flags
//   opcode     in   instr[6:0] from the IR; captured in ID
//   bcond      in   branch condition from the ALU, used in EX
//   mem_ready  in   memory completes the current access this cycle
//   pc_write   out  PC update enable, one pulse per retired instruction
//   pc_source  out  00 PC+4, 01 PC+imm, 10 ALU result
//   ir_write   out  latch the fetched instruction
//   i_or_d     out  0 fetch address (PC), 1 data address (ALUOut)
//   mem_read   out  memory read request
//   mem_write  out  memory write request
//   reg_write  out  register-file write enable
//   wb_sel     out  00 ALU, 01 memory data, 10 PC+4
//   alu_op     out  00 add, 01 branch compare, 10 funct-decoded
//   is_halted  out  sticky halt flag
//   mem_err    out  sticky memory-timeout flag
//   retired    out  number of pc_write pulses, wraps at 2^32

module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        bcond,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_op,
    output logic        is_halted,
    output logic        mem_err,
    output logic [31:0] retired
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     op_q;
    logic [CW-1:0]  wait_cnt_q;
    logic [31:0]    retired_q;
    logic           is_halted_q;
    logic           mem_err_q;
    logic           timeout;

    function automatic logic op_known(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
               (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // Strobes are decoded straight from the current state so that an asynchronous
    // reset removes any in-flight write/update in the same cycle.
    always_comb begin
        state_d   = state_q;
        timeout   = 1'b0;
        pc_write  = 1'b0;
        pc_source = 2'b00;
        ir_write  = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        alu_op    = 2'b00;

        case (state_q)
            ST_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_ID;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_ID: begin
                if (opcode == OP_ECALL) begin
                    state_d = ST_HALT;
                end else if (op_known(opcode)) begin
                    state_d = ST_EX;
                end else begin
                    // Unrecognised opcode retires as a NOP.
                    pc_write = 1'b1;
                    state_d  = ST_IF;
                end
            end
            ST_EX: begin
                case (op_q)
                    OP_R, OP_I: begin
                        alu_op  = 2'b10;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_d = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op    = 2'b01;
                        pc_write  = 1'b1;
                        pc_source = bcond ? 2'b01 : 2'b00;
                        state_d   = ST_IF;
                    end
                    OP_JAL, OP_JALR: begin
                        state_d = ST_WB;
                    end
                    default: begin
                        pc_write = 1'b1;
                        state_d  = ST_IF;
                    end
                endcase
            end
            ST_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
                if (mem_ready) begin
                    if (op_q == OP_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        state_d  = ST_IF;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                case (op_q)
                    OP_LOAD: wb_sel = 2'b01;
                    OP_JAL: begin
                        wb_sel    = 2'b10;
                        pc_source = 2'b01;
                    end
                    OP_JALR: begin
                        wb_sel    = 2'b10;
                        pc_source = 2'b10;
                    end
                    default: wb_sel = 2'b00;
                endcase
                state_d = ST_IF;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IF;
            op_q        <= '0;
            wait_cnt_q  <= '0;
            retired_q   <= '0;
            is_halted_q <= 1'b0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ID) begin
                op_q <= opcode;
            end
            if (state_d != state_q) begin
                wait_cnt_q <= '0;
            end else if (((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready) begin
                wait_cnt_q <= wait_cnt_q + CW'(1);
            end
            if (pc_write) begin
                retired_q <= retired_q + 32'd1;
            end
            if (state_d == ST_HALT) begin
                is_halted_q <= 1'b1;
            end
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    assign is_halted = is_halted_q;
    assign mem_err   = mem_err_q;
    assign retired   = retired_q;

endmodule
